// File: rtl/hps_reset_sequencer.sv
// hps_reset_sequencer: serialises cold/warm/debug HPS reset requests with ack wait and holdoff.
// Optional pushbutton source (debounce, short press = warm, long press = cold) under HPS_RST_PB_EN.
module hps_reset_sequencer #(
  parameter int PULSE_CYCLES      = 16,
  parameter int ACK_TIMEOUT       = 65536,
  parameter int HOLDOFF_CYCLES    = 1024,
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int LONG_PRESS_CYCLES = 2000000
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic [2:0] issp_req,
  input  logic       pb_n,
  input  logic       h2f_reset_n,
  output logic       cold_req_n,
  output logic       warm_req_n,
  output logic       debug_req_n,
  output logic       busy,
  output logic [1:0] last_src,
  output logic       ack_timeout
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ASSERT    = 3'd1;
  localparam logic [2:0] WAIT_LOW  = 3'd2;
  localparam logic [2:0] WAIT_HIGH = 3'd3;
  localparam logic [2:0] HOLDOFF   = 3'd4;
  logic [2:0] issp_s1_q, issp_s2_q, issp_s3_q;
  logic h2f_s1_q, h2f_s2_q;
  logic [2:0] state_q, state_d, pend_q, pend_d, req_n_q, req_n_d;
  logic [2:0] grant, rise, pb_set;
  logic [1:0] last_src_q, last_src_d;
  logic ack_to_q, ack_to_d, to_hit, waiting;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [AW-1:0] ack_cnt_q, ack_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  always_comb begin
    rise = issp_s2_q & ~issp_s3_q;
    grant = (state_q != IDLE) ? 3'b000 :
            pend_q[0] ? 3'b001 : pend_q[1] ? 3'b010 : pend_q[2] ? 3'b100 : 3'b000;
    // a fresh edge of the type being granted this cycle is absorbed by the grant
    pend_d = (pend_q | rise | pb_set) & ~grant;
    last_src_d = grant[0] ? 2'd1 : grant[1] ? 2'd2 : grant[2] ? 2'd3 : last_src_q;
    waiting = (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);
    to_hit = ack_cnt_q == ACK_LAST;
    ack_to_d = ack_to_q;
    state_d = state_q;
    case (state_q)
      IDLE:      if (|grant) state_d = ASSERT;
      ASSERT:    if (pulse_cnt_q == PULSE_LAST) state_d = (last_src_q == 2'd3) ? HOLDOFF : WAIT_LOW;
      WAIT_LOW:  if (!h2f_s2_q) state_d = WAIT_HIGH;
                 else if (to_hit) begin
                   state_d = HOLDOFF;
                   ack_to_d = 1'b1;
                 end
      WAIT_HIGH: if (h2f_s2_q) state_d = HOLDOFF;
                 else if (to_hit) begin
                   state_d = HOLDOFF;
                   ack_to_d = 1'b1;
                 end
      HOLDOFF:   if (hold_cnt_q == HOLD_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // outputs are registered from the next state so the pulse starts on the ASSERT edge
    req_n_d = (state_d == ASSERT) ?
              ~{last_src_d == 2'd3, last_src_d == 2'd2, last_src_d == 2'd1} : 3'b111;
    pulse_cnt_d = (state_q != ASSERT) ? '0 :
                  (pulse_cnt_q == PULSE_LAST) ? pulse_cnt_q : pulse_cnt_q + PW'(1);
    ack_cnt_d = !waiting ? '0 : (ack_cnt_q == ACK_LAST) ? ack_cnt_q : ack_cnt_q + AW'(1);
    hold_cnt_d = (state_q != HOLDOFF) ? '0 :
                 (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + HW'(1);
  end
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      issp_s1_q   <= '0;
      issp_s2_q   <= '0;
      issp_s3_q   <= '0;
      h2f_s1_q    <= 1'b1;
      h2f_s2_q    <= 1'b1;
      state_q     <= IDLE;
      pend_q      <= '0;
      req_n_q     <= 3'b111;
      last_src_q  <= '0;
      ack_to_q    <= 1'b0;
      pulse_cnt_q <= '0;
      ack_cnt_q   <= '0;
      hold_cnt_q  <= '0;
    end else begin
      issp_s1_q   <= issp_req;
      issp_s2_q   <= issp_s1_q;
      issp_s3_q   <= issp_s2_q;
      h2f_s1_q    <= h2f_reset_n;
      h2f_s2_q    <= h2f_s1_q;
      state_q     <= state_d;
      pend_q      <= pend_d;
      req_n_q     <= req_n_d;
      last_src_q  <= last_src_d;
      ack_to_q    <= ack_to_d;
      pulse_cnt_q <= pulse_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end
`ifdef HPS_RST_PB_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
  logic pb_s1_q, pb_s2_q, pb_db_q, pb_db_d, long_q, long_d;
  logic pb_diff, pb_flip, pb_rel, long_hit;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [LW-1:0] press_cnt_q, press_cnt_d;
  always_comb begin
    pb_diff = pb_s2_q != pb_db_q;
    pb_flip = pb_diff && (db_cnt_q == DB_LAST);
    pb_rel = pb_flip && pb_s2_q;
    pb_db_d = pb_flip ? pb_s2_q : pb_db_q;
    db_cnt_d = !pb_diff ? '0 : (db_cnt_q == DB_LAST) ? db_cnt_q : db_cnt_q + DW'(1);
    press_cnt_d = pb_db_q ? '0 : (press_cnt_q == LP_LAST) ? press_cnt_q : press_cnt_q + LW'(1);
    // long press fires cold once and suppresses the warm on release
    long_hit = !pb_db_q && (press_cnt_q == LP_LAST) && !long_q;
    long_d = pb_rel ? 1'b0 : (long_q | long_hit);
    pb_set = {1'b0, pb_rel && !long_q, long_hit};
  end
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      pb_s1_q     <= 1'b1;
      pb_s2_q     <= 1'b1;
      pb_db_q     <= 1'b1;
      long_q      <= 1'b0;
      db_cnt_q    <= '0;
      press_cnt_q <= '0;
    end else begin
      pb_s1_q     <= pb_n;
      pb_s2_q     <= pb_s1_q;
      pb_db_q     <= pb_db_d;
      long_q      <= long_d;
      db_cnt_q    <= db_cnt_d;
      press_cnt_q <= press_cnt_d;
    end
  end
`else
  logic unused_pb;
  assign unused_pb = pb_n;
  assign pb_set = 3'b000;
`endif
  assign cold_req_n  = req_n_q[0];
  assign warm_req_n  = req_n_q[1];
  assign debug_req_n = req_n_q[2];
  assign busy        = state_q != IDLE;
  assign last_src    = last_src_q;
  assign ack_timeout = ack_to_q;
endmodule
